// File: rtl/tiny_cpu.sv
// tiny_cpu: self-contained 8-bit accumulator CPU with a 256x8 unified memory.
// Instructions take three cycles (fetch, decode, execute); LD adds a writeback cycle.
module tiny_cpu #(
  parameter string MEM_FILE  = "program.hex",
  parameter int    MEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    LOADWB = 3'd3
  } state_t;

  state_t      exec_state;
  logic [7:0]  instr;
  logic [7:0]  rA;
  logic [7:0]  rB;
  logic [7:0]  rM;
  logic [7:0]  rP;
  logic        c;

  logic [7:0]  mem [MEM_DEPTH];
  logic [7:0]  rdata;
  logic [7:0]  raddr;
  logic        we;

  logic        isLd;
  logic        isSt;
  logic [7:0]  aluRes;
  logic        aluC;
  logic [8:0]  sum9;
  logic [7:0]  movSrc;
  logic        jmpTake;

  assign isLd = (instr[7:4] == 4'b1010);
  assign isSt = (instr[7:4] == 4'b1011);

  // The memory port normally follows the program counter; only LD's execute
  // cycle redirects it to the pointer register so LOADWB sees mem[rM].
  assign raddr = ((exec_state == EXEC) && isLd) ? rM : rP;
  assign we    = (exec_state == EXEC) && isSt && !reset;
  assign sum9  = {1'b0, rA} + {1'b0, rB};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[rM] <= rA;
    end
    rdata <= mem[raddr];
  end

  always_comb begin
    aluRes = rA;
    aluC   = c;
    case (instr[5:3])
      3'd0: begin
        aluRes = sum9[7:0];
        aluC   = sum9[8];
      end
      3'd1: begin
        aluRes = rA - rB;
        aluC   = (rA < rB);
      end
      3'd2: aluRes = rA & rB;
      3'd3: aluRes = rA | rB;
      3'd4: aluRes = rA ^ rB;
      3'd5: aluRes = ~rA;
      3'd6: begin
        aluRes = {rA[6:0], 1'b0};
        aluC   = rA[7];
      end
      default: begin
        aluRes = {1'b0, rA[7:1]};
        aluC   = rA[0];
      end
    endcase
  end

  always_comb begin
    movSrc = rA;
    case (instr[1:0])
      2'd0: movSrc = rA;
      2'd1: movSrc = rB;
      2'd2: movSrc = rM;
      default: movSrc = rP;
    endcase
  end

  always_comb begin
    jmpTake = 1'b0;
    case (instr[5:4])
      2'd0: jmpTake = 1'b1;
      2'd1: jmpTake = (rA == 8'h00);
      2'd2: jmpTake = (rA != 8'h00);
      default: jmpTake = c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_state <= FETCH;
      instr      <= 8'h00;
      rA         <= 8'h00;
      rB         <= 8'h00;
      rM         <= 8'h00;
      rP         <= 8'h00;
      c          <= 1'b0;
    end else begin
      case (exec_state)
        FETCH: begin
          exec_state <= DECODE;
        end
        DECODE: begin
          instr      <= rdata;
          rP         <= rP + 8'd1;
          exec_state <= EXEC;
        end
        EXEC: begin
          exec_state <= FETCH;
          case (instr[7:6])
            2'b00: begin
              if (instr[2]) begin
                rB <= aluRes;
              end else begin
                rA <= aluRes;
              end
              c <= aluC;
            end
            2'b01: begin
              case (instr[3:2])
                2'd0: rA <= movSrc;
                2'd1: rB <= movSrc;
                2'd2: rM <= movSrc;
                default: rP <= movSrc;
              endcase
            end
            2'b10: begin
              case (instr[5:4])
                2'd0: rA <= {4'h0, instr[3:0]};
                2'd1: rA <= {instr[3:0], rA[3:0]};
                2'd2: exec_state <= LOADWB;
                default: ;
              endcase
            end
            default: begin
              if (jmpTake) begin
                rP <= rM;
              end
            end
          endcase
        end
        LOADWB: begin
          rA         <= rdata;
          exec_state <= FETCH;
        end
        default: begin
          exec_state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_cpu.sv
// Scoreboard bench for tiny_cpu: an instruction-level model predicts the register
// state and cycle count of every retired instruction; a monitor compares on retirement.
module tb_tiny_cpu;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tiny_cpu #(.MEM_FILE(""), .MEM_DEPTH(256)) dut (
    .clk(clk),
    .reset(reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] regs;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int errors = 0;
  int checks = 0;

  logic [7:0] img  [256];
  logic [7:0] mMem [256];
  logic [7:0] mA, mB, mM, mP;
  logic       mC;

  int monPrev = 0;
  int monCyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] regByCode(input logic [1:0] code);
    case (code)
      2'd0: return mA;
      2'd1: return mB;
      2'd2: return mM;
      default: return mP;
    endcase
  endfunction

  task automatic writeReg(input logic [1:0] code, input logic [7:0] val);
    case (code)
      2'd0: mA = val;
      2'd1: mB = val;
      2'd2: mM = val;
      default: mP = val;
    endcase
  endtask

  // Architectural model: one call executes one whole instruction.
  task automatic modelStep(output int cyc);
    logic [7:0] ins;
    int a, b, r;
    bit take;
    ins = mMem[mP];
    mP = mP + 8'd1;
    cyc = 3;
    a = int'(mA);
    b = int'(mB);
    r = 0;
    case (ins[7:6])
      2'd0: begin
        case (ins[5:3])
          3'd0: begin r = a + b; mC = (r > 255); end
          3'd1: begin r = a - b; mC = (a < b); end
          3'd2: r = a & b;
          3'd3: r = a | b;
          3'd4: r = a ^ b;
          3'd5: r = ~a;
          3'd6: begin r = a * 2; mC = (a >= 128); end
          default: begin r = a / 2; mC = (a % 2 == 1); end
        endcase
        if (ins[2]) mB = r[7:0];
        else mA = r[7:0];
      end
      2'd1: writeReg(ins[3:2], regByCode(ins[1:0]));
      2'd2: begin
        case (ins[5:4])
          2'd0: mA = 8'(int'(ins[3:0]));
          2'd1: mA = 8'(int'(ins[3:0]) * 16 + a % 16);
          2'd2: begin mA = mMem[mM]; cyc = 4; end
          default: mMem[mM] = mA;
        endcase
      end
      default: begin
        case (ins[5:4])
          2'd0: take = 1'b1;
          2'd1: take = (mA == 8'h00);
          2'd2: take = (mA != 8'h00);
          default: take = mC;
        endcase
        if (take) mP = mM;
      end
    endcase
  endtask

  // Retirement monitor: an instruction completes when the FSM re-enters state 0.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (reset) begin
      monPrev = 0;
      monCyc = 0;
    end else begin
      monCyc++;
      if (int'(dut.exec_state) == 0 && monPrev != 0) begin
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("regs", 64'({dut.rA, dut.rB, dut.rM, dut.rP, dut.c}), 64'(e.regs));
          checkOutput("latency", 64'(monCyc), 64'(e.cyc));
        end
        monCyc = 0;
      end
      monPrev = int'(dut.exec_state);
    end
  end

  task automatic clearImg();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic applyStimulus(input string tag, input int nInstr);
    int budget;
    int bad;
    int cyc;
    exp_t e;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      dut.mem[i] = img[i];
      mMem[i] = img[i];
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_reset"},
                64'({dut.rA, dut.rB, dut.rM, dut.rP, dut.c, dut.instr, 3'(dut.exec_state)}), 64'd0);
    mA = 8'h00; mB = 8'h00; mM = 8'h00; mP = 8'h00; mC = 1'b0;
    expQ.delete();
    for (int n = 0; n < nInstr; n++) begin
      modelStep(cyc);
      e.regs = {mA, mB, mM, mP, mC};
      e.cyc = cyc;
      expQ.push_back(e);
    end
    reset = 1'b0;
    budget = nInstr * 4 + 10;
    while (expQ.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (expQ.size() != 0) begin
      checkOutput({tag, "_timeout"}, 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut.mem[i] !== mMem[i]) bad++;
    end
    checkOutput({tag, "_mem"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    clearImg();
    img[0] = 8'h85; img[1] = 8'h95;
    applyStimulus("t2", 2);
    checkOutput("t2_rA", 64'(dut.rA), 64'h55);

    clearImg();
    img[0] = 8'h83; img[1] = 8'h44; img[2] = 8'h85; img[3] = 8'h00;
    applyStimulus("t3", 4);
    checkOutput("t3_rA", 64'(dut.rA), 64'h08);
    checkOutput("t3_rB", 64'(dut.rB), 64'h03);
    checkOutput("t3_c", 64'(dut.c), 64'h0);

    clearImg();
    img[0] = 8'h8F; img[1] = 8'h9F; img[2] = 8'h44; img[3] = 8'h81;
    img[4] = 8'h00; img[5] = 8'hF0;
    applyStimulus("t4", 6);
    checkOutput("t4_rA", 64'(dut.rA), 64'h00);
    checkOutput("t4_c", 64'(dut.c), 64'h1);

    clearImg();
    img[0] = 8'h80; img[1] = 8'h98; img[2] = 8'h48; img[3] = 8'h8A;
    img[4] = 8'h95; img[5] = 8'hB0; img[6] = 8'h80; img[7] = 8'hA0;
    applyStimulus("t5", 8);
    checkOutput("t5_rA", 64'(dut.rA), 64'h5A);
    checkOutput("t5_mem80", 64'(dut.mem[8'h80]), 64'h5A);

    clearImg();
    img[0] = 8'h82; img[1] = 8'h48; img[2] = 8'hC0;
    applyStimulus("t6", 9);
    checkOutput("t6_rM", 64'(dut.rM), 64'h02);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      applyStimulus("rand", 60);
    end

    reset = 1'b1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
